// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count, flush and sticky error flags.
// Define FIFO_WATERMARK_EN to drive almost_full/almost_empty from count; otherwise both are tied low.
module sync_fifo_fwft #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int             DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic              wr_ok;
  logic              rd_ok;
  logic              overflow_set;
  logic              underflow_set;

  // Reset enters asynchronously but leaves only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  // flush swallows the whole cycle, including any error it would otherwise raise
  assign overflow_set  = !flush && wr_en && !wr_ok;
  assign underflow_set = !flush && rd_en && empty;

  always_ff @(posedge clk) begin
    if (!flush && wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

`ifdef FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);

  assign almost_full  = (count >= AFULL_LV);
  assign almost_empty = (count <= AEMPTY_LV);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench for sync_fifo_fwft: stimulus queues expected pops, a negedge monitor checks them.
module tb_sync_fifo_fwft;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        clr_err;
  logic        almost_full;
  logic        almost_empty;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q[$];
  int          exp_count;

`ifdef FIFO_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  sync_fifo_fwft dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Drive one cycle of inputs, let the edge take them, then return everything to idle.
  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] d,
                               input logic f, input logic c);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    flush   = f;
    clr_err = c;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic writeWord(input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic popWord(input logic [31:0] expected);
    exp_q.push_back(expected);
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic checkLevels(input string tag, input int c);
    checkOutput({tag, ".count"}, 32'(count), 32'(c));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(c == 0));
    checkOutput({tag, ".full"}, 32'(full), 32'(c == 8));
    checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'(WM && (c >= 6)));
    checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(WM && (c <= 2)));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL pop_unexpected: got 0x%0h, expected no pop", rd_data);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        if (rd_data === e) passes++;
        else $display("[TB] FAIL pop_data: got 0x%0h, expected 0x%0h", rd_data, e);
      end
    end
  end

  initial begin
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; flush = 1'b0; clr_err = 1'b0;
    doReset();

    $display("[TB] reset state");
    checkLevels("reset", 0);
    checkOutput("reset.overflow", 32'(overflow), 32'd0);
    checkOutput("reset.underflow", 32'(underflow), 32'd0);
    checkOutput("reset.rd_data", rd_data, 32'd0);

    $display("[TB] fill 0x11..0x88");
    for (int i = 1; i <= 8; i++) begin
      writeWord(32'(i * 'h11));
      checkLevels($sformatf("fill%0d", i), i);
      checkOutput("fill.rd_head", rd_data, 32'h11);
    end

    writeWord(32'hDEAD);
    checkOutput("ovf.overflow", 32'(overflow), 32'd1);
    checkOutput("ovf.count", 32'(count), 32'd8);
    checkOutput("ovf.rd_data", rd_data, 32'h11);

    for (int i = 1; i <= 8; i++) popWord(32'(i * 'h11));
    checkLevels("drain", 0);
    checkOutput("drain.rd_data", rd_data, 32'd0);
    checkOutput("drain.overflow_sticky", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr.overflow", 32'(overflow), 32'd0);

    $display("[TB] full with simultaneous read and write");
    for (int i = 1; i <= 8; i++) writeWord(32'(i * 'h11));
    exp_q.push_back(32'h11);
    applyStimulus(1'b1, 1'b1, 32'h99, 1'b0, 1'b0);
    checkOutput("fullrw.count", 32'(count), 32'd8);
    checkOutput("fullrw.overflow", 32'(overflow), 32'd0);
    checkOutput("fullrw.rd_data", rd_data, 32'h22);
    for (int i = 2; i <= 8; i++) popWord(32'(i * 'h11));
    popWord(32'h99);
    checkLevels("fullrw.drain", 0);

    $display("[TB] empty with simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 32'h42, 1'b0, 1'b0);
    checkOutput("emptyrw.count", 32'(count), 32'd1);
    checkOutput("emptyrw.rd_data", rd_data, 32'h42);
    checkOutput("emptyrw.underflow", 32'(underflow), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("emptyrw.clr", 32'(underflow), 32'd0);
    popWord(32'h42);
    checkLevels("emptyrw.drain", 0);

    $display("[TB] interleaved 20-word stream");
    exp_count = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 4) begin
        writeWord(32'h100 + 32'(i));
        exp_count++;
      end else begin
        exp_q.push_back(32'h100 + 32'(i - 4));
        applyStimulus(1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      end
      checkOutput("stream.count", 32'(count), 32'(exp_count));
    end
    for (int i = 16; i < 20; i++) popWord(32'h100 + 32'(i));
    checkLevels("stream.drain", 0);
    checkOutput("stream.underflow", 32'(underflow), 32'd0);

    $display("[TB] flush");
    for (int i = 0; i < 5; i++) writeWord(32'h200 + 32'(i));
    checkOutput("flush.pre_count", 32'(count), 32'd5);
    applyStimulus(1'b1, 1'b0, 32'hBAD, 1'b1, 1'b0);
    checkLevels("flush5", 0);
    checkOutput("flush5.rd_data", rd_data, 32'd0);
    for (int i = 0; i < 8; i++) writeWord(32'h300 + 32'(i));
    applyStimulus(1'b1, 1'b0, 32'hBAD, 1'b1, 1'b0);
    checkLevels("flushfull", 0);
    checkOutput("flushfull.overflow", 32'(overflow), 32'd0);
    writeWord(32'h55);
    checkOutput("postflush.rd_data", rd_data, 32'h55);
    popWord(32'h55);

    $display("[TB] asynchronous reset mid-transfer");
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checkOutput("pre_rst.underflow", 32'(underflow), 32'd1);
    for (int i = 0; i < 3; i++) writeWord(32'h400 + 32'(i));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst.count", 32'(count), 32'd0);
    checkOutput("async_rst.empty", 32'(empty), 32'd1);
    checkOutput("async_rst.rd_data", rd_data, 32'd0);
    checkOutput("async_rst.underflow", 32'(underflow), 32'd0);
    doReset();
    checkLevels("post_rst", 0);

    checkOutput("scoreboard.leftover", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Parametrised single-clock first-word-fall-through (FWFT) FIFO for the DMA datapath; next generation of the 8x32 fifo storage.
- Generalises width and depth, and adds occupancy count, flush, sticky overflow/underflow error flags and optional watermark flags.
- Sits between the DMA read-engine and write-engine when both run on the same clock.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (default 8).
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH (only with watermark feature).
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (only with watermark feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- flush  in  1  synchronous clear of pointers and count.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read/pop request; pops the word currently shown on rd_data.
- rd_data  out  DATA_W  head-of-queue word (FWFT).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while the write could not be accepted.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.
- almost_full  out  1  watermark flag.
- almost_empty  out  1  watermark flag.

Behaviour:
- Storage: DEPTH x DATA_W register array, written on posedge clk. Storage is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits; the low ADDR_W bits index the array, and the MSB is the wrap bit.
- full = (MSBs differ) && (low bits equal). empty = (wr_ptr == rd_ptr). count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0, almost_full = 0, almost_empty = 1 (feature on), rd_data = 0.
- rd_data is combinational: mem[rd_ptr[ADDR_W-1:0]] when !empty, else all zeros. A word written at edge N is visible on rd_data after edge N (zero-cycle read latency).
- wr_ok = wr_en && (!full || rd_en). A full FIFO with simultaneous rd_en accepts the write: the read frees a slot, count stays DEPTH, and the popped word is the old head.
- rd_ok = rd_en && !empty. On an empty FIFO, a simultaneous write is accepted and the read is rejected, so underflow sets.
- On wr_ok: mem[wr_ptr] <= wr_data and wr_ptr increments. On rd_ok: rd_ptr increments. Both may occur in the same cycle, and count is then unchanged.
- Pointer wrap: the low bits roll from DEPTH-1 to 0 and the MSB toggles. No special handling is needed.
- Error flags:
  - overflow sets on wr_en && !wr_ok.
  - underflow sets on rd_en && empty.
  - Both hold until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
- flush has priority over wr_en and rd_en in the same cycle: pointers go to 0 and count goes to 0, the write is dropped, and error flags are unaffected.
  - A flush while full does not set overflow, even if wr_en is high.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronously). Stale array contents are never visible because empty = 1 forces rd_data = 0.
- Flags are derived combinationally from the registered pointers. There is no registered-flag latency.

Optional Feature:
- Macro: FIFO_WATERMARK_EN.
- Defined: almost_full = (count >= AFULL_TH) and almost_empty = (count <= AEMPTY_TH), both combinational from count.
- Not defined: almost_full is tied to 0 and almost_empty is tied to 0. AFULL_TH and AEMPTY_TH are ignored, and the ports remain present.

Test Plan:
- Reset, then write 0x11..0x88 (8 words, default params) -> full = 1, count = 8, rd_data = 0x11 immediately after the first write.
- Full FIFO, wr_en = 1 with rd_en = 0, wr_data = 0xDEAD -> write dropped, overflow = 1, count = 8; pop all 8 words -> 0x11..0x88 in order, then empty = 1 and rd_data = 0.
- Full FIFO, wr_en = rd_en = 1, wr_data = 0x99 -> 0x11 popped, count = 8, new tail 0x99, overflow stays 0.
- Empty FIFO, wr_en = rd_en = 1, wr_data = 0x42 -> count = 1, rd_data = 0x42, underflow = 1; then clr_err -> underflow = 0.
- Write 20 words and read 20 words interleaved (both pointers wrap twice) -> data order preserved, count never exceeds 8; flush with 5 words queued -> count = 0, empty = 1 next cycle.
- With FIFO_WATERMARK_EN defined: fill 0->8 -> almost_empty high for count 0..2, almost_full high for count 6..8. Without the macro, both flags stay 0.
